// File: rtl/can_tx_scheduler_pkg.sv
// can_tx_scheduler shared types and defaults.
// State encoding plus byte width and timing constants.
package can_pkg;

    localparam int CAN_DATA_W      = 8;
    localparam int CAN_DEPTH       = 8;
    localparam int CAN_TIMEOUT_CYC = 64;
    localparam int CAN_MAX_RETRY   = 2;
    localparam int CAN_GAP_CYC     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Host write port and controller-side bundle of can_tx_scheduler.
// master = host/controller side, slave = the scheduler.
interface can_tx_scheduler_if
    import can_pkg::*;
#(
    parameter int DATA_W = CAN_DATA_W,
    parameter int CNT_W  = $clog2(CAN_DEPTH) + 1
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] ctrl_data;
    logic              ctrl_tx_req;
    logic              ctrl_tx_done;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic              sent_pulse;
    logic              drop_pulse;

    modport master (
        output wr_data, wr_valid, ctrl_tx_done,
        input  wr_ready, ctrl_data, ctrl_tx_req,
        input  fifo_count, busy, sent_pulse, drop_pulse
    );

    modport slave (
        input  wr_data, wr_valid, ctrl_tx_done,
        output wr_ready, ctrl_data, ctrl_tx_req,
        output fifo_count, busy, sent_pulse, drop_pulse
    );

endinterface

// File: rtl/can_tx_scheduler_fifo.sv
// can_byte_fifo: synchronous byte queue for the tx scheduler.
// Occupancy kept in its own counter so full/empty never alias.
module can_byte_fifo
    import can_pkg::*;
#(
    parameter int DATA_W = CAN_DATA_W,
    parameter int DEPTH  = CAN_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointers and occupancy from the accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: feeds queued host bytes to can_controller,
// one request per byte, with timeout retry/drop and an idle gap.
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int DATA_W      = CAN_DATA_W,
    parameter int DEPTH       = CAN_DEPTH,
    parameter int TIMEOUT_CYC = CAN_TIMEOUT_CYC,
    parameter int MAX_RETRY   = CAN_MAX_RETRY,
    parameter int GAP_CYC     = CAN_GAP_CYC
) (
    input  logic         clk,
    input  logic         reset,
    can_tx_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int GW = $clog2(GAP_CYC + 1);

    tx_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              sent_q, sent_d;
    logic              drop_q, drop_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign fifo_push = bus.wr_valid && !fifo_full;

    can_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (bus.wr_data),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next state, attempt timer/retry, gap counter and pulse requests.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        gap_d    = gap_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        sent_d   = 1'b0;
        drop_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    data_d  = fifo_head;
                    retry_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.ctrl_tx_done) begin
                    fifo_pop = 1'b1;
                    sent_d   = 1'b1;
                    gap_d    = '0;
                    state_d  = GAP;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = REQ;
                    end else begin
                        fifo_pop = 1'b1;
                        drop_d   = 1'b1;
                        gap_d    = '0;
                        state_d  = GAP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            sent_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            req_q   <= req_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.wr_ready    = !fifo_full;
    assign bus.ctrl_data   = data_q;
    assign bus.ctrl_tx_req = req_q;
    assign bus.fifo_count  = fifo_count;
    assign bus.busy        = (state_q != IDLE);
    assign bus.sent_pulse  = sent_q;
    assign bus.drop_pulse  = drop_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: transaction-level model
// compared every cycle, plus directed literal checks per scenario.
module tb_can_tx_scheduler;
    import can_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int TO    = 64;
    localparam int MR    = 2;
    localparam int GAP   = 2;
    localparam int CW    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    can_tx_scheduler_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    can_tx_scheduler #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MR),
        .GAP_CYC     (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: byte queue plus cycle numbers of the scheduled events.
    logic [7:0] mq[$];
    bit         m_ok   = 1'b0;
    bit         m_act  = 1'b0;
    int         m_att  = 0;
    int         m_req  = -10;
    int         m_idle = 0;
    int         m_sent = -10;
    int         m_drop = -10;
    logic [7:0] m_data = 8'h00;
    bit         m_acc;
    bit         m_pop;
    logic [7:0] m_wd;

    // What the DUT actually did, for the directed checks.
    int         req_cyc[$];
    logic [7:0] req_dat[$];
    int         sent_n   = 0;
    int         drop_n   = 0;
    int         drop_cyc = -1;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("req", 32'(bus.ctrl_tx_req), 32'(m_act && cyc == m_req));
            chk("data", 32'(bus.ctrl_data), 32'(m_data));
            chk("count", 32'(bus.fifo_count), 32'(mq.size()));
            chk("ready", 32'(bus.wr_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(bus.busy), 32'(m_act || cyc < m_idle));
            chk("sent", 32'(bus.sent_pulse), 32'(cyc == m_sent));
            chk("drop", 32'(bus.drop_pulse), 32'(cyc == m_drop));
        end
        if (bus.ctrl_tx_req === 1'b1) begin
            req_cyc.push_back(cyc);
            req_dat.push_back(bus.ctrl_data);
        end
        if (bus.sent_pulse === 1'b1) sent_n++;
        if (bus.drop_pulse === 1'b1) begin
            drop_n++;
            drop_cyc = cyc;
        end
        if (reset) begin
            mq.delete();
            m_act  = 1'b0;
            m_idle = cyc + 1;
            m_data = 8'h00;
            m_sent = -10;
            m_drop = -10;
            m_ok   = 1'b1;
        end else begin
            m_acc = bus.wr_valid && (mq.size() < DEPTH);
            m_wd  = bus.wr_data;
            m_pop = 1'b0;
            if (m_act && cyc > m_req) begin
                if (bus.ctrl_tx_done) begin
                    m_pop  = 1'b1;
                    m_sent = cyc + 1;
                    m_act  = 1'b0;
                    m_idle = cyc + 1 + GAP;
                end else if (cyc == m_req + TO) begin
                    if (m_att <= MR) begin
                        m_att++;
                        m_req = cyc + 1;
                    end else begin
                        m_pop  = 1'b1;
                        m_drop = cyc + 1;
                        m_act  = 1'b0;
                        m_idle = cyc + 1 + GAP;
                    end
                end
            end else if (!m_act && cyc >= m_idle && mq.size() > 0) begin
                m_act  = 1'b1;
                m_att  = 1;
                m_req  = cyc + 1;
                m_data = mq[0];
            end
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(m_wd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_req_n(input int idx, output int rc);
        int n;
        n = 0;
        while (req_cyc.size() <= idx && n < 400) begin
            tick();
            n++;
        end
        if (req_cyc.size() > idx) begin
            rc = req_cyc[idx];
        end else begin
            chk("req_wait_bound", 32'(0), 32'(1));
            rc = cyc;
        end
    endtask

    task automatic done_at(input int c);
        while (cyc < c) tick();
        bus.ctrl_tx_done = 1'b1;
        tick();
        bus.ctrl_tx_done = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int k, b, r, r1, r2, r3, d, s0, d0;
    logic [7:0] t2_exp [3];

    initial begin
        bus.wr_data      = '0;
        bus.wr_valid     = 1'b0;
        bus.ctrl_tx_done = 1'b0;
        reset            = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(bus.fifo_count), 32'(0));
        chk("rst_ready", 32'(bus.wr_ready), 32'(1));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_data", 32'(bus.ctrl_data), 32'(0));
        chk("rst_req", 32'(bus.ctrl_tx_req), 32'(0));

        // 1: single byte, done 5 cycles after the request.
        s0 = sent_n;
        b  = req_cyc.size();
        k  = cyc;
        push1(8'hA5);
        wait_req_n(b, r);
        chk("t1_req_lat", 32'(r - k), 32'(2));
        chk("t1_data", 32'(req_dat[b]), 32'h A5);
        d = r + 5;
        done_at(d);
        while (cyc < d + GAP) tick();
        chk("t1_busy_last", 32'(bus.busy), 32'(1));
        tick();
        chk("t1_busy_fall", 32'(bus.busy), 32'(0));
        chk("t1_sent", 32'(sent_n - s0), 32'(1));
        chk("t1_count", 32'(bus.fifo_count), 32'(0));
        chk("t1_nreq", 32'(req_cyc.size() - b), 32'(1));
        repeat (3) tick();

        // 2: three back-to-back bytes, done 3 cycles after each request.
        t2_exp[0] = 8'hA5;
        t2_exp[1] = 8'h3C;
        t2_exp[2] = 8'h5A;
        s0 = sent_n;
        b  = req_cyc.size();
        push1(8'hA5);
        push1(8'h3C);
        push1(8'h5A);
        d = 0;
        for (int i = 0; i < 3; i++) begin
            wait_req_n(b + i, r);
            chk("t2_order", 32'(req_dat[b + i]), 32'(t2_exp[i]));
            if (i > 0) chk("t2_gap", 32'(r - d), 32'(4));
            d = r + 3;
            done_at(d);
        end
        repeat (6) tick();
        chk("t2_sent", 32'(sent_n - s0), 32'(3));
        chk("t2_count", 32'(bus.fifo_count), 32'(0));

        // 3: nine pushes with no done; ninth refused.
        for (int i = 1; i <= 9; i++) push1(8'(i));
        chk("t3_count", 32'(bus.fifo_count), 32'(8));
        chk("t3_ready", 32'(bus.wr_ready), 32'(0));
        chk("t3_data", 32'(bus.ctrl_data), 32'h01);
        pulse_reset();
        tick();

        // 4: timeout, two retries, then drop.
        b  = req_cyc.size();
        d0 = drop_n;
        push1(8'hC3);
        wait_req_n(b, r1);
        wait_req_n(b + 1, r2);
        wait_req_n(b + 2, r3);
        chk("t4_space1", 32'(r2 - r1), 32'(65));
        chk("t4_space2", 32'(r3 - r2), 32'(65));
        chk("t4_data1", 32'(req_dat[b]), 32'hC3);
        chk("t4_data3", 32'(req_dat[b + 2]), 32'hC3);
        while (cyc < r3 + TO + 3) tick();
        chk("t4_drop_n", 32'(drop_n - d0), 32'(1));
        chk("t4_drop_at", 32'(drop_cyc - r3), 32'(65));
        chk("t4_count", 32'(bus.fifo_count), 32'(0));
        repeat (10) tick();
        chk("t4_nreq", 32'(req_cyc.size() - b), 32'(3));

        // 5: done in the last WAIT cycle of the attempt wins.
        b  = req_cyc.size();
        s0 = sent_n;
        d0 = drop_n;
        push1(8'h5E);
        wait_req_n(b, r);
        done_at(r + TO);
        repeat (8) tick();
        chk("t5_sent", 32'(sent_n - s0), 32'(1));
        chk("t5_drop", 32'(drop_n - d0), 32'(0));
        chk("t5_nreq", 32'(req_cyc.size() - b), 32'(1));

        // 6: reset in WAIT with bytes queued.
        b  = req_cyc.size();
        s0 = sent_n;
        d0 = drop_n;
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        wait_req_n(b, r);
        while (cyc < r + 3) tick();
        pulse_reset();
        chk("t6_count", 32'(bus.fifo_count), 32'(0));
        chk("t6_busy", 32'(bus.busy), 32'(0));
        chk("t6_data", 32'(bus.ctrl_data), 32'(0));
        chk("t6_sentp", 32'(bus.sent_pulse), 32'(0));
        chk("t6_dropp", 32'(bus.drop_pulse), 32'(0));
        bus.ctrl_tx_done = 1'b1;
        tick();
        bus.ctrl_tx_done = 1'b0;
        repeat (8) tick();
        chk("t6_sent", 32'(sent_n - s0), 32'(0));
        chk("t6_drop", 32'(drop_n - d0), 32'(0));
        chk("t6_nreq", 32'(req_cyc.size() - b), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
